param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath
Interface
REQ-001 SHALL have parameter WIDTH, default 16: register/ALU/memory word width, >=8.
REQ-002 SHALL have parameter NREGS, default 16: register count, power of 2, >=4; SW=log2(NREGS).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 8: max MEM-state cycles awaiting mem_ack (timeout build only).
REQ-004 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  in  1  command present.
REQ-007 SHALL have port cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_op  in  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 PASS_A.
REQ-009 SHALL have port cmd_a_sel / cmd_b_sel / cmd_d_sel  in  SW each  operand A, operand B, destination/store-source register.
REQ-010 SHALL have port cmd_imm_sel  in  2  bit0 replaces A with cmd_imm, bit1 replaces B with cmd_imm.
REQ-011 SHALL have port cmd_imm  in  WIDTH  immediate.
REQ-012 SHALL have port cmd_dst  in  2  00 discard, 01 write ALU result to reg d, 10 load mem[result] into reg d, 11 store reg d to mem[result].
REQ-013 SHALL have port cmd_pc_inc  in  1  increment r0 (PC) on retire.
REQ-014 SHALL have port mem_req / mem_we  out  1 each  memory request, write enable (high for store).
REQ-015 SHALL have port mem_addr / mem_wdata  out  WIDTH each  address = latched result; write data.
REQ-016 SHALL have port mem_ack  in  1; mem_rdata  in  WIDTH.
REQ-017 SHALL have port result  out  WIDTH  last registered ALU result.
REQ-018 SHALL have port registers  out  NREGS*WIDTH  register r at bits [r*WIDTH +: WIDTH].
REQ-019 SHALL have port overflow / errorbit  out  NREGS each  per-register sticky-until-rewrite status bits.
REQ-020 SHALL have port zeroflag / signflag  out  NREGS each  combinational: reg==0, reg MSB.
Function
REQ-021 SHALL implement FSM IDLE->EXEC on accept, latching op, selects, operand values, cmd_dst, cmd_pc_inc.
REQ-022 SHALL in EXEC register ALU result into result; dst 00/01 retire to IDLE at that edge; dst 10/11 go MEM.
REQ-023 SHALL hold mem_req=1 and stable mem_addr/mem_wdata/mem_we throughout MEM, 0 elsewhere; mem_ack outside MEM ignored.
REQ-024 SHALL on mem_ack in MEM retire to IDLE; load writes mem_rdata to reg d, clears overflow[d] and errorbit[d].
REQ-025 SHALL on dst 01 write ALU result to reg d, overflow[d]=signed overflow (ADD/SUB only, else 0), errorbit[d]=ALU error.
REQ-026 SHALL flag ALU error when SHL/SHR amount (B, unsigned) >= WIDTH; result 0 then; arithmetic wraps modulo 2^WIDTH.
REQ-027 SHALL on retire with pc_inc add 1 to r0 (wrapping); if the same retire writes r0, the written value wins, no increment.
REQ-028 SHALL give one-command latency: cmd_ready reasserts 2 cycles after accept for dst 00/01, 2+N cycles for memory ops acked after N MEM cycles.
Reset
REQ-029 SHALL on resetn low immediately force IDLE, registers/result/overflow/errorbit/timeout counter to 0, mem_req 0, cmd_ready 0 until resetn high.
Configuration
REQ-030 SHALL with PARAM_DATAPATH_TIMEOUT_EN defined count MEM cycles; after MEM_TIMEOUT cycles without ack retire to IDLE, set errorbit[d], leave reg d unchanged, still apply pc_inc.
REQ-031 SHALL without PARAM_DATAPATH_TIMEOUT_EN wait in MEM indefinitely; MEM_TIMEOUT unused.
Verification
REQ-032 SHALL cover: PASS_A imm 0x7FFF->r1, then ADD r1+imm 1->r2 -> r2=0x8000, overflow[2]=1, signflag[2]=1.
REQ-033 SHALL cover: SHL imm A=1, imm B=16, dst 01 d=3 -> r3=0, errorbit[3]=1, zeroflag[3]=1.
REQ-034 SHALL cover: load addr 0x0040, ack with 0xBEEF on 3rd MEM cycle -> mem_req high exactly 3 cycles, r4=0xBEEF, cmd_ready back 5 cycles after accept.
REQ-035 SHALL cover: pc_inc with d=5 -> r0 0->1; pc_inc with dst 01 d=0 value 0x0100 -> r0=0x0100.
REQ-036 SHALL cover: timeout build, MEM_TIMEOUT=8, store never acked -> IDLE after 8 MEM cycles, errorbit[d]=1, mem_req 0.
REQ-037 SHALL cover: resetn low mid-MEM -> mem_req 0 same cycle, all registers 0, late mem_ack ignored.

Source files
------------

// File: rtl/param_datapath.sv
// param_datapath: one-command-at-a-time register-file datapath with an ALU
// and a single-outstanding memory port. IDLE accepts a command, EXEC computes
// and registers the ALU result, MEM (loads/stores only) waits for mem_ack.
// Optional build macro PARAM_DATAPATH_TIMEOUT_EN abandons a memory access after
// MEM_TIMEOUT MEM cycles without an acknowledge.
module param_datapath #(
    parameter int WIDTH       = 16,
    parameter int NREGS       = 16,
    parameter int MEM_TIMEOUT = 8,
    localparam int SW         = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [SW-1:0]          cmd_a_sel,
    input  logic [SW-1:0]          cmd_b_sel,
    input  logic [SW-1:0]          cmd_d_sel,
    input  logic [1:0]             cmd_imm_sel,
    input  logic [WIDTH-1:0]       cmd_imm,
    input  logic [1:0]             cmd_dst,
    input  logic                   cmd_pc_inc,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic                   mem_ack,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic [WIDTH-1:0]       result,
    output logic [NREGS*WIDTH-1:0] registers,
    output logic [NREGS-1:0]       overflow,
    output logic [NREGS-1:0]       errorbit,
    output logic [NREGS-1:0]       zeroflag,
    output logic [NREGS-1:0]       signflag
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_MEM  = 2'b10;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_PASS = 3'd7;

    // Shift amounts at or beyond the word width are an ALU error.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    logic [1:0]       state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_val_reg, b_val_reg;
    logic [SW-1:0]    d_sel_reg;
    logic [1:0]       dst_reg;
    logic             pc_inc_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] overflow_reg, errorbit_reg;

    logic             accept;
    logic [WIDTH-1:0] alu_result, alu_sum, alu_diff;
    logic             alu_ovf, alu_err;
    logic             mem_active, exec_retire, ack_retire, timeout_retire, retire;
    logic             wr_en, wr_ovf, wr_err, pc_bump;
    logic [WIDTH-1:0] wr_data;

    // Ready only when idle and not held in reset.
    assign cmd_ready  = resetn && (state_reg == S_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign mem_active = (state_reg == S_MEM);

    // Memory port is driven only while waiting in MEM; quiet (all zero) elsewhere.
    assign mem_req   = mem_active;
    assign mem_we    = mem_active && (dst_reg == 2'b11);
    assign mem_addr  = mem_active ? result_reg : '0;
    assign mem_wdata = mem_active ? regs_reg[d_sel_reg] : '0;
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign errorbit  = errorbit_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg_out
            assign registers[gi*WIDTH +: WIDTH] = regs_reg[gi];
            assign zeroflag[gi] = (regs_reg[gi] == '0);
            assign signflag[gi] = regs_reg[gi][WIDTH-1];
        end
    endgenerate

    // ALU on the latched operands; overflow only meaningful for ADD/SUB.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        alu_sum    = a_val_reg + b_val_reg;
        alu_diff   = a_val_reg - b_val_reg;
        case (op_reg)
            OP_ADD: begin
                alu_result = alu_sum;
                alu_ovf = (a_val_reg[WIDTH-1] == b_val_reg[WIDTH-1]) &&
                          (alu_sum[WIDTH-1] != a_val_reg[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = alu_diff;
                alu_ovf = (a_val_reg[WIDTH-1] != b_val_reg[WIDTH-1]) &&
                          (alu_diff[WIDTH-1] != a_val_reg[WIDTH-1]);
            end
            OP_AND:  alu_result = a_val_reg & b_val_reg;
            OP_OR:   alu_result = a_val_reg | b_val_reg;
            OP_XOR:  alu_result = a_val_reg ^ b_val_reg;
            OP_SHL: begin
                if (b_val_reg >= SHIFT_LIMIT) alu_err = 1'b1;
                else                          alu_result = a_val_reg << b_val_reg;
            end
            OP_SHR: begin
                if (b_val_reg >= SHIFT_LIMIT) alu_err = 1'b1;
                else                          alu_result = a_val_reg >> b_val_reg;
            end
            default: alu_result = a_val_reg;
        endcase
    end

`ifdef PARAM_DATAPATH_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_reg;

    assign timeout_retire = mem_active && !mem_ack && (tmo_cnt_reg == CW'(MEM_TIMEOUT - 1));

    // Counts MEM cycles of the current access; cleared whenever not in MEM.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                     tmo_cnt_reg <= '0;
        else if (mem_active && !retire)  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        else                             tmo_cnt_reg <= '0;
    end
`else
    assign timeout_retire = 1'b0;
`endif

    // Retire decode: which edge finishes the command and what it writes back.
    always_comb begin
        exec_retire = (state_reg == S_EXEC) && !dst_reg[1];
        ack_retire  = mem_active && mem_ack;
        retire      = exec_retire || ack_retire || timeout_retire;
        wr_en       = (exec_retire && dst_reg == 2'b01) || (ack_retire && dst_reg == 2'b10);
        wr_data     = mem_active ? mem_rdata : alu_result;
        wr_ovf      = mem_active ? 1'b0 : alu_ovf;
        wr_err      = mem_active ? 1'b0 : alu_err;
        // A retire that writes r0 takes precedence over the PC increment.
        pc_bump     = retire && pc_inc_reg && !(wr_en && d_sel_reg == '0);
    end

    // Control FSM plus command latch and registered ALU result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            a_val_reg  <= '0;
            b_val_reg  <= '0;
            d_sel_reg  <= '0;
            dst_reg    <= '0;
            pc_inc_reg <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) begin
                    state_reg  <= S_EXEC;
                    op_reg     <= cmd_op;
                    a_val_reg  <= cmd_imm_sel[0] ? cmd_imm : regs_reg[cmd_a_sel];
                    b_val_reg  <= cmd_imm_sel[1] ? cmd_imm : regs_reg[cmd_b_sel];
                    d_sel_reg  <= cmd_d_sel;
                    dst_reg    <= cmd_dst;
                    pc_inc_reg <= cmd_pc_inc;
                end
                S_EXEC: begin
                    result_reg <= alu_result;
                    state_reg  <= dst_reg[1] ? S_MEM : S_IDLE;
                end
                S_MEM:   if (retire) state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Register file with sticky per-register status, written only on retire.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
            overflow_reg <= '0;
            errorbit_reg <= '0;
        end else begin
            if (wr_en) begin
                regs_reg[d_sel_reg]     <= wr_data;
                overflow_reg[d_sel_reg] <= wr_ovf;
                errorbit_reg[d_sel_reg] <= wr_err;
            end else if (timeout_retire) begin
                errorbit_reg[d_sel_reg] <= 1'b1;
            end
            if (pc_bump) regs_reg[0] <= regs_reg[0] + 1'b1;
        end
    end

endmodule

// File: tb/tb_param_datapath.sv
// Directed self-checking bench for param_datapath (WIDTH=16, NREGS=16).
// The timeout scenario is exercised only when PARAM_DATAPATH_TIMEOUT_EN is defined.
module tb_param_datapath;

    logic         clock = 1'b0;
    logic         resetn;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_op;
    logic [3:0]   cmd_a_sel, cmd_b_sel, cmd_d_sel;
    logic [1:0]   cmd_imm_sel;
    logic [15:0]  cmd_imm;
    logic [1:0]   cmd_dst;
    logic         cmd_pc_inc;
    logic         mem_req, mem_we, mem_ack;
    logic [15:0]  mem_addr, mem_wdata, mem_rdata, result;
    logic [255:0] registers;
    logic [15:0]  overflow, errorbit, zeroflag, signflag;

    int n_assert = 0;
    int n_fail   = 0;
    int lat, reqs;
    logic [15:0] addr_seen, wdata_seen;
    logic        we_seen;

    always #5 clock = ~clock;

    param_datapath #(.WIDTH(16), .NREGS(16), .MEM_TIMEOUT(8)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a_sel(cmd_a_sel), .cmd_b_sel(cmd_b_sel), .cmd_d_sel(cmd_d_sel),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
        .cmd_pc_inc(cmd_pc_inc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .result(result), .registers(registers),
        .overflow(overflow), .errorbit(errorbit), .zeroflag(zeroflag),
        .signflag(signflag)
    );

    function automatic logic [15:0] r(input int i);
        return registers[i*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one command, acknowledge memory on MEM cycle ack_at (0 = never),
    // return cycles from accept until cmd_ready and number of mem_req cycles.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic [1:0] isel, input logic [15:0] imm,
                           input logic [1:0] dst, input logic pc, input int ack_at,
                           input logic [15:0] rdata);
        check("ready_before_accept", cmd_ready, 1);
        cmd_op = op; cmd_a_sel = a; cmd_b_sel = b; cmd_d_sel = d;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_dst = dst; cmd_pc_inc = pc;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 1; reqs = 0;
        addr_seen = '0; wdata_seen = '0; we_seen = 1'b0;
        while (!cmd_ready && lat < 40) begin
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    addr_seen = mem_addr; wdata_seen = mem_wdata; we_seen = mem_we;
                end
                mem_ack   = (reqs == ack_at);
                mem_rdata = rdata;
            end
            step();
            mem_ack = 1'b0;
            lat++;
        end
        $display("cmd op=%0d d=%0d dst=%0d pc=%0d -> latency %0d, mem_req cycles %0d, result %h",
                 op, d, dst, pc, lat, reqs, result);
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        cmd_op = '0; cmd_a_sel = '0; cmd_b_sel = '0; cmd_d_sel = '0;
        cmd_imm_sel = '0; cmd_imm = '0; cmd_dst = '0; cmd_pc_inc = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ready", cmd_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_regs_or", |registers, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_errorbit", errorbit, 0);
        check("rst_zeroflag", zeroflag, 16'hFFFF);
        resetn = 1'b1;
        step();
        check("ready_after_reset", cmd_ready, 1);

        // PASS_A 0x7FFF -> r1 ; ADD r1 + 1 -> r2 overflows into the sign bit
        run_cmd(3'd7, 0, 0, 1, 2'b01, 16'h7FFF, 2'b01, 0, 0, 0);
        check("pass_lat", lat, 2);
        check("pass_r1", r(1), 16'h7FFF);
        run_cmd(3'd0, 1, 0, 2, 2'b10, 16'h0001, 2'b01, 0, 0, 0);
        check("add_r2", r(2), 16'h8000);
        check("add_result", result, 16'h8000);
        check("add_ovf2", overflow[2], 1);
        check("add_sign2", signflag[2], 1);
        check("pass_ovf1", overflow[1], 0);

        // SUB r2 - r1 = 0x0001 with signed overflow
        run_cmd(3'd1, 2, 1, 6, 2'b00, 16'h0000, 2'b01, 0, 0, 0);
        check("sub_r6", r(6), 16'h0001);
        check("sub_ovf6", overflow[6], 1);

        // Logic ops
        run_cmd(3'd4, 1, 0, 7, 2'b10, 16'h00FF, 2'b01, 0, 0, 0);
        check("xor_r7", r(7), 16'h7F00);
        check("xor_ovf7", overflow[7], 0);
        run_cmd(3'd3, 7, 2, 8, 2'b00, 16'h0000, 2'b01, 0, 0, 0);
        check("or_r8", r(8), 16'hFF00);
        check("or_sign8", signflag[8], 1);
        run_cmd(3'd2, 8, 0, 9, 2'b10, 16'h0F0F, 2'b01, 0, 0, 0);
        check("and_r9", r(9), 16'h0F00);

        // Shifts: in-range SHR, out-of-range SHL
        run_cmd(3'd6, 2, 0, 10, 2'b10, 16'd15, 2'b01, 0, 0, 0);
        check("shr_r10", r(10), 16'h0001);
        check("shr_err10", errorbit[10], 0);
        cmd_imm = 16'd1;
        run_cmd(3'd5, 0, 0, 3, 2'b11, 16'd16, 2'b01, 0, 0, 0);
        check("shl_r3", r(3), 16'h0000);
        check("shl_err3", errorbit[3], 1);
        check("shl_zero3", zeroflag[3], 1);
        run_cmd(3'd7, 0, 0, 3, 2'b01, 16'h0005, 2'b01, 0, 0, 0);
        check("rewrite_r3", r(3), 16'h0005);
        check("rewrite_err3", errorbit[3], 0);

        // Discard: result updates, no register written
        run_cmd(3'd0, 0, 0, 3, 2'b11, 16'h0003, 2'b00, 0, 0, 0);
        check("discard_lat", lat, 2);
        check("discard_result", result, 16'h0006);
        check("discard_r3", r(3), 16'h0005);

        // Load 0x0040 acked on 3rd MEM cycle; errorbit[4] set first to see it cleared
        run_cmd(3'd6, 0, 0, 4, 2'b11, 16'd20, 2'b01, 0, 0, 0);
        check("pre_load_err4", errorbit[4], 1);
        run_cmd(3'd7, 0, 0, 4, 2'b01, 16'h0040, 2'b10, 0, 3, 16'hBEEF);
        check("load_lat", lat, 5);
        check("load_req_cycles", reqs, 3);
        check("load_addr", addr_seen, 16'h0040);
        check("load_we", we_seen, 0);
        check("load_r4", r(4), 16'hBEEF);
        check("load_err4", errorbit[4], 0);
        check("load_req_after", mem_req, 0);

        // Store r2 to 0x0080, acked on first MEM cycle
        run_cmd(3'd7, 0, 0, 2, 2'b01, 16'h0080, 2'b11, 0, 1, 16'h0000);
        check("store_lat", lat, 3);
        check("store_we", we_seen, 1);
        check("store_addr", addr_seen, 16'h0080);
        check("store_wdata", wdata_seen, 16'h8000);
        check("store_r2", r(2), 16'h8000);

        // PC increment, and a write to r0 overriding the increment
        run_cmd(3'd7, 0, 0, 5, 2'b01, 16'h1234, 2'b01, 1, 0, 0);
        check("pc_r0_inc", r(0), 16'h0001);
        check("pc_r5", r(5), 16'h1234);
        run_cmd(3'd7, 0, 0, 0, 2'b01, 16'h0100, 2'b01, 1, 0, 0);
        check("pc_r0_write_wins", r(0), 16'h0100);
        run_cmd(3'd0, 0, 0, 0, 2'b11, 16'h0000, 2'b00, 1, 0, 0);
        check("pc_r0_discard_inc", r(0), 16'h0101);

        // mem_ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step(); step();
        mem_ack = 1'b0;
        check("idle_ack_ready", cmd_ready, 1);
        check("idle_ack_r0", r(0), 16'h0101);
        check("idle_ack_req", mem_req, 0);

`ifdef PARAM_DATAPATH_TIMEOUT_EN
        // Store never acknowledged: abandoned after 8 MEM cycles
        run_cmd(3'd7, 0, 0, 2, 2'b01, 16'h0090, 2'b11, 1, 0, 0);
        check("tmo_lat", lat, 10);
        check("tmo_req_cycles", reqs, 8);
        check("tmo_err2", errorbit[2], 1);
        check("tmo_r2", r(2), 16'h8000);
        check("tmo_mem_req", mem_req, 0);
        check("tmo_pc", r(0), 16'h0102);
`endif

        // Reset in the middle of MEM
        cmd_op = 3'd7; cmd_imm_sel = 2'b01; cmd_imm = 16'h0050; cmd_dst = 2'b10;
        cmd_d_sel = 4'd11; cmd_pc_inc = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_mem_req", mem_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_regs_or", |registers, 0);
        check("rst_mid_ready", cmd_ready, 0);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        step();
        resetn = 1'b1;
        step(); step();
        mem_ack = 1'b0;
        check("late_ack_r11", r(11), 16'h0000);
        check("late_ack_regs_or", |registers, 0);
        check("late_ack_ready", cmd_ready, 1);
        check("late_ack_req", mem_req, 0);
        $display("reset mid-MEM: mem_req %0d, cmd_ready %0d, r11 %h", mem_req, cmd_ready, r(11));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
